// File: rtl/jtpopeye_dma_resp.sv
// jtpopeye_dma_resp: main-CPU side responder for the video object DMA.
// Owns the shared object RAM and arbitrates it between the Z80 and DMA reads.
// It answers busrq_n with busak_n and stalls RAM accesses from the Z80 while
// the bus is granted.
// Optional feature macro: JTPOPEYE_DMA_TIMEOUT_EN. When it is defined, a grant
// that is held too long is force-released, dma_abort pulses for one clock, and
// the requester is locked out until it lets go of busrq_n.
module jtpopeye_dma_resp #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          cpu_mreq_n,
  input  logic          cpu_ram_cs,
  input  logic          cpu_wr_n,
  input  logic          cpu_rd_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait_n,
  input  logic          busrq_n,
  output logic          busak_n,
  input  logic          dma_cs,
  input  logic [AW-1:0] AD_DMA,
  output logic [7:0]    DD_DMA,
  output logic          dma_abort
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITB   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          rq_s;
  logic          in_grant;
  logic          cpu_access;
  logic          cpu_we;
  logic          timeout_hit;
  logic          lock;
  logic [AW-1:0] ram_addr;
  logic [7:0]    mem [0:DEPTH-1];

  assign in_grant   = (state == GRANT);
  assign cpu_access = cpu_ram_cs && (!cpu_wr_n || !cpu_rd_n);

  // The RAM has a single port: DMA owns it during the grant, the CPU otherwise.
  assign ram_addr = in_grant ? AD_DMA : cpu_addr;

  // A reset cycle discards whatever write the CPU has pending.
  assign cpu_we = !in_grant && cpu_cen && cpu_ram_cs && !cpu_wr_n && !rst;

  // Hold the CPU off the RAM while video owns it; other accesses run freely.
  assign cpu_wait_n = !(in_grant && cpu_access);

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] grant_cnt;

  assign timeout_hit = in_grant && (grant_cnt == CNT_W'(TIMEOUT - 1));

  // Count clocks spent in the grant; the count restarts with every new grant.
  always_ff @(posedge clk) begin
    if (rst || !in_grant) grant_cnt <= '0;
    else                  grant_cnt <= grant_cnt + 1'b1;
  end

  // Abort pulse plus lockout until the requester has released busrq_n once.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_abort <= 1'b0;
      lock      <= 1'b0;
    end else begin
      dma_abort <= timeout_hit;
      if (timeout_hit) lock <= 1'b1;
      else if (rq_s)   lock <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign lock           = 1'b0;
  assign dma_abort      = 1'b0;
`endif

  // Register busrq_n once before the arbiter looks at it.
  always_ff @(posedge clk) begin
    if (rst) rq_s <= 1'b1;
    else     rq_s <= busrq_n;
  end

  // Arbiter state register; busak_n follows the state that is being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busak_n <= 1'b1;
    end else begin
      state   <= state_nx;
      busak_n <= (state_nx != GRANT);
    end
  end

  // Grant only between Z80 memory cycles, and release on a CPU clock enable.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rq_s && !lock) state_nx = WAITB;
      WAITB: begin
        if (rq_s)                        state_nx = IDLE;
        else if (cpu_cen && cpu_mreq_n)  state_nx = GRANT;
      end
      GRANT:   if ((rq_s && cpu_cen) || timeout_hit) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Object RAM storage; its contents survive reset.
  always_ff @(posedge clk) begin
    if (cpu_we) mem[ram_addr] <= cpu_dout;
  end

  // Registered read data for both clients; each holds its value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_din <= 8'h00;
      DD_DMA  <= 8'h00;
    end else begin
      if (!in_grant && cpu_ram_cs && !cpu_rd_n) cpu_din <= mem[ram_addr];
      if (in_grant && dma_cs)                   DD_DMA  <= mem[ram_addr];
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma_resp.sv
// Self-checking bench for jtpopeye_dma_resp: random RAM contents tracked in
// a byte-array model, directed bus-request scenarios, and stall/reset cases.
module tb_jtpopeye_dma_resp;

  localparam int AW         = 10;
  localparam int TB_TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_cen;
  logic          cpu_mreq_n;
  logic          cpu_ram_cs;
  logic          cpu_wr_n;
  logic          cpu_rd_n;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_wait_n;
  logic          busrq_n;
  logic          busak_n;
  logic          dma_cs;
  logic [AW-1:0] AD_DMA;
  logic [7:0]    DD_DMA;
  logic          dma_abort;

  int            checks = 0;
  int            passes = 0;
  int            abort_cycles = 0;
  logic [7:0]    model [0:(1<<AW)-1];
  logic [AW-1:0] addr_q[$];
  logic [7:0]    last_dd;

  jtpopeye_dma_resp #(.AW(AW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_cen    (cpu_cen),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_ram_cs (cpu_ram_cs),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_wait_n (cpu_wait_n),
    .busrq_n    (busrq_n),
    .busak_n    (busak_n),
    .dma_cs     (dma_cs),
    .AD_DMA     (AD_DMA),
    .DD_DMA     (DD_DMA),
    .dma_abort  (dma_abort)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Count every clock during which the abort pulse is high.
  always @(posedge clk) begin
    if (dma_abort === 1'b1) abort_cycles++;
  end

  // Hard stop in case a scenario wedges the simulation.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic wr_n, input logic rd_n,
                               input logic [AW-1:0] a, input logic [7:0] d);
    cpu_ram_cs = cs;
    cpu_wr_n   = wr_n;
    cpu_rd_n   = rd_n;
    cpu_addr   = a;
    cpu_dout   = d;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, a, d);
    tick();
    model[a] = d;
    applyStimulus(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 8'h00);
    tick();
    checkOutput(tag, {8'h00, cpu_din}, {8'h00, model[a]});
    applyStimulus(1'b0, 1'b1, 1'b1, a, 8'h00);
  endtask

  task automatic wait_busak(input logic val, input int bound, input string tag);
    int n;
    n = 0;
    while (busak_n !== val && n < bound) begin
      tick();
      n++;
    end
    checkOutput(tag, {15'h0, busak_n}, {15'h0, val});
  endtask

  task automatic request_bus();
    cpu_mreq_n = 1'b1;
    busrq_n    = 1'b0;
    wait_busak(1'b0, 10, "grant");
  endtask

  task automatic drop_bus();
    busrq_n = 1'b1;
    wait_busak(1'b1, 10, "release");
    tick();
  endtask

  task automatic dma_read(input logic [AW-1:0] a, input string tag);
    dma_cs = 1'b1;
    AD_DMA = a;
    tick();
    checkOutput(tag, {8'h00, DD_DMA}, {8'h00, model[a]});
    last_dd = model[a];
    dma_cs  = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          low_seen;
    int            n;
    int            grant_cycles;

    rst        = 1'b1;
    cpu_cen    = 1'b1;
    cpu_mreq_n = 1'b1;
    busrq_n    = 1'b1;
    dma_cs     = 1'b0;
    AD_DMA     = '0;
    last_dd    = 8'h00;
    applyStimulus(1'b0, 1'b1, 1'b1, '0, 8'h00);
    tick();
    tick();
    checkOutput("rst_busak_n",    {15'h0, busak_n},    16'h1);
    checkOutput("rst_cpu_wait_n", {15'h0, cpu_wait_n}, 16'h1);
    checkOutput("rst_dd_dma",     {8'h00, DD_DMA},     16'h0);
    checkOutput("rst_cpu_din",    {8'h00, cpu_din},    16'h0);
    checkOutput("rst_dma_abort",  {15'h0, dma_abort},  16'h0);
    rst = 1'b0;
    tick();

    // Random fill, then the fixed locations the directed cases rely on.
    for (int i = 0; i < 12; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      d = 8'($urandom_range(0, 255));
      cpu_write(a, d);
      addr_q.push_back(a);
    end
    cpu_write(10'h010, 8'($urandom_range(0, 255)));
    cpu_write(10'h200, 8'h11);
    cpu_write(10'h123, 8'hA5);

    // Read-after-write from the CPU side.
    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      d = 8'($urandom_range(0, 255));
      cpu_write(a, d);
      cpu_read(a, "cpu_raw");
      addr_q.push_back(a);
    end

    // DMA reads during a grant.
    request_bus();
    dma_read(10'h123, "dma_a5");
    for (int i = 0; i < 8; i++) begin
      a = addr_q[$urandom_range(0, addr_q.size() - 1)];
      dma_read(a, "dma_rand");
    end
    AD_DMA = 10'h123;
    tick();
    checkOutput("dd_hold_no_cs", {8'h00, DD_DMA}, {8'h00, last_dd});
    drop_bus();

    // dma_cs outside the grant must not update DD_DMA.
    dma_cs = 1'b1;
    AD_DMA = 10'h010;
    tick();
    tick();
    checkOutput("dd_hold_idle", {8'h00, DD_DMA}, {8'h00, last_dd});
    dma_cs = 1'b0;

    // No grant while the Z80 is inside a memory cycle.
    cpu_mreq_n = 1'b0;
    busrq_n    = 1'b0;
    low_seen   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busak_n !== 1'b1) low_seen = 1'b1;
    end
    cpu_mreq_n = 1'b1;
    cpu_cen    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (busak_n !== 1'b1) low_seen = 1'b1;
    end
    checkOutput("mreq_blocks_grant", {15'h0, low_seen}, 16'h0);
    cpu_cen = 1'b1;
    tick();
    checkOutput("grant_at_cen", {15'h0, busak_n}, 16'h0);

    // Stall behaviour while granted.
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h010, 8'h3C);
    #1;
    checkOutput("no_stall_other", {15'h0, cpu_wait_n}, 16'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h010, 8'h00);
    #1;
    checkOutput("stall_read", {15'h0, cpu_wait_n}, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'h010, 8'h3C);
    tick();
    tick();
    checkOutput("stall_write", {15'h0, cpu_wait_n}, 16'h0);
    dma_read(10'h010, "dma_write_blocked");
    busrq_n = 1'b0;
    busrq_n = 1'b1;
    n = 0;
    while (cpu_wait_n !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("wait_released", {15'h0, cpu_wait_n}, 16'h1);
    checkOutput("busak_at_release", {15'h0, busak_n}, 16'h1);
    tick();
    model[10'h010] = 8'h3C;
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h010, 8'h00);
    cpu_read(10'h010, "cpu_after_stall");
    request_bus();
    dma_read(10'h010, "dma_3c");
    drop_bus();

    // One-clock request pulse inside a memory cycle never grants.
    cpu_mreq_n = 1'b0;
    busrq_n    = 1'b0;
    tick();
    busrq_n  = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busak_n !== 1'b1) low_seen = 1'b1;
    end
    checkOutput("pulse_no_grant", {15'h0, low_seen}, 16'h0);
    cpu_mreq_n = 1'b1;

    // Reset in the middle of a grant with a CPU write pending.
    request_bus();
    dma_read(10'h123, "dma_before_rst");
    applyStimulus(1'b1, 1'b0, 1'b1, 10'h200, 8'h77);
    #1;
    checkOutput("wait_before_rst", {15'h0, cpu_wait_n}, 16'h0);
    rst = 1'b1;
    tick();
    checkOutput("rst_grant_busak", {15'h0, busak_n},    16'h1);
    checkOutput("rst_grant_dd",    {8'h00, DD_DMA},     16'h0);
    checkOutput("rst_grant_wait",  {15'h0, cpu_wait_n}, 16'h1);
    rst     = 1'b0;
    busrq_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h200, 8'h00);
    tick();
    cpu_read(10'h200, "write_dropped");

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    // Stuck requester: forced release, one abort pulse, lockout until release.
    tick();
    abort_cycles = 0;
    request_bus();
    grant_cycles = 0;
    n = 0;
    while (busak_n === 1'b0 && n < 100) begin
      grant_cycles++;
      tick();
      n++;
    end
    checkOutput("timeout_len", 16'(grant_cycles), 16'(TB_TIMEOUT));
    low_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busak_n !== 1'b1) low_seen = 1'b1;
    end
    checkOutput("no_regrant_locked", {15'h0, low_seen}, 16'h0);
    checkOutput("abort_pulses", 16'(abort_cycles), 16'h1);
    busrq_n = 1'b1;
    tick();
    tick();
    tick();
    request_bus();
    drop_bus();
`else
    checkOutput("abort_tied", 16'(abort_cycles), 16'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/jtpopeye_dma_resp.md
Name: jtpopeye_dma_resp

Overview:
- Main-CPU-side responder for the object DMA issued by the video section.
- Owns the 1 KB shared object RAM. Arbitrates it between Z80 accesses and video DMA reads.
- Answers the video bus request (busrq_n) with busak_n and stalls the CPU while the bus is granted.
- Serves DMA read bytes on DD_DMA from the address on AD_DMA.

Parameters:
- AW, 10, object RAM address width (depth 2^AW bytes).
- TIMEOUT, 4096, clk cycles of continuous grant before forced release (used only with DMA_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_cen  in  1  Z80 clock enable.
- cpu_mreq_n  in  1  Z80 memory cycle in progress, active low.
- cpu_ram_cs  in  1  Z80 addresses the object RAM.
- cpu_wr_n  in  1  Z80 write strobe.
- cpu_rd_n  in  1  Z80 read strobe.
- cpu_addr  in  AW  Z80 address into object RAM.
- cpu_dout  in  8  Z80 write data.
- cpu_din  out  8  object RAM read data to Z80.
- cpu_wait_n  out  1  Z80 WAIT, active low.
- busrq_n  in  1  DMA bus request from video, active low.
- busak_n  out  1  DMA bus acknowledge, active low.
- dma_cs  in  1  video requests a DMA read this cycle.
- AD_DMA  in  AW  DMA read address.
- DD_DMA  out  8  DMA read data.
- dma_abort  out  1  one-clk pulse on forced release (0 when the feature is out).

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: busak_n=1, cpu_wait_n=1, DD_DMA=0, cpu_din=0, dma_abort=0, state=IDLE. RAM contents are not cleared.
- busrq_n is registered once on clk (rq_s) before use.

State machine (advances only on clk):
- IDLE: when rq_s=0, go to WAITB.
- WAITB:
  - rq_s=1: return to IDLE with no busak_n pulse.
  - On a cpu_cen cycle with cpu_mreq_n=1: go to GRANT and set busak_n=0 on the same edge.
- GRANT:
  - busak_n=0.
  - When rq_s=1 and cpu_cen=1: go to RELEASE.
- RELEASE: busak_n=1. Next clk go to IDLE.
  - busrq_n low again while in RELEASE is serviced from IDLE, so the minimum re-grant gap is 1 IDLE cycle.

CPU port:
- Outside GRANT:
  - Write: mem[cpu_addr] <= cpu_dout when cpu_cen & cpu_ram_cs & ~cpu_wr_n.
  - Read: cpu_din registered from mem[cpu_addr] every clk when cpu_ram_cs & ~cpu_rd_n.
- In GRANT with cpu_ram_cs=1 and (~cpu_wr_n or ~cpu_rd_n):
  - cpu_wait_n=0 combinationally and the write is blocked.
  - cpu_wait_n returns to 1 in RELEASE. The stalled access then completes normally.
- CPU accesses that do not target the RAM are never stalled.

DMA port:
- In GRANT with dma_cs=1: DD_DMA <= mem[AD_DMA]. Data is valid 1 clk after the address.
- dma_cs=0, or dma_cs outside GRANT: DD_DMA holds its last value.
- AD_DMA wraps naturally at 2^AW. No range check.

Memory and boundary cases:
- Single-port RAM. The port mux selects AD_DMA in GRANT and cpu_addr otherwise, so reads and writes never collide.
- Read-after-write from the CPU returns the new data 1 clk after the write edge.
- rst asserted mid-GRANT: busak_n=1 and cpu_wait_n=1 on the next clk edge. Any pending CPU write is dropped.

Optional Feature:
- Macro: JTPOPEYE_DMA_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT)+1 counts clk cycles in GRANT and is cleared outside GRANT.
  - On reaching TIMEOUT, go to RELEASE and pulse dma_abort=1 for 1 clk.
  - The block then stays in IDLE, ignoring busrq_n, until rq_s has been seen high once. This prevents re-grant to a stuck requester.
- Undefined: no counter, dma_abort tied 0, and GRANT lasts until busrq_n goes high.

Test Plan:
- CPU writes 0xA5 to addr 0x123 with no request, then DMA: busrq_n=0, wait for busak_n=0, dma_cs=1 with AD_DMA=0x123 -> DD_DMA=0xA5 one clk later.
- busrq_n=0 while cpu_mreq_n=0 across 3 cpu_cen -> busak_n stays 1. Raise cpu_mreq_n -> busak_n=0 at that cpu_cen edge.
- In GRANT, CPU writes 0x3C to 0x010 -> cpu_wait_n=0 and mem[0x010] unchanged. Drop the request -> busak_n=1, cpu_wait_n=1, and the write lands; a DMA read later returns 0x3C.
- Pulse busrq_n low for 1 clk with cpu_mreq_n=0 -> returns to IDLE and busak_n never goes low.
- Assert rst for 1 clk in GRANT -> busak_n=1, DD_DMA=0, cpu_wait_n=1 next edge.
- With JTPOPEYE_DMA_TIMEOUT_EN and TIMEOUT=16, hold busrq_n=0 -> busak_n=1 after 16 grant clks, one dma_abort pulse, no re-grant until busrq_n has toggled high.
